// File: rtl/or_bist_pkg.sv
// Shared FSM state type and default parameter values for the OR-gate BIST.
package or_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_WIDTH      = 10;
    localparam int unsigned DEF_LATENCY    = 0;
    localparam int unsigned DEF_ERR_W      = 16;
    localparam bit          DEF_CONTINUOUS = 1'b0;

endpackage

// File: rtl/bist_delay.sv
// DEPTH-stage shift register carrying data plus a valid tag; DEPTH = 0 is a wire.
module bist_delay #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data,
    input  logic         valid,
    output logic [W-1:0] data_dly,
    output logic         valid_dly
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign data_dly  = data;
            assign valid_dly = valid;

            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
        end else begin : g_pipe
            logic [W-1:0]     data_q [DEPTH];
            logic [DEPTH-1:0] valid_q;

            // Only the valid tags need reset; data is ignored while its tag is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= valid;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
                data_q[0] <= data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end

            assign data_dly  = data_q[DEPTH-1];
            assign valid_dly = valid_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/or_gate_bist.sv
// Exhaustive BIST for a WIDTH-input OR gate: sweeps every stimulus value and
// compares the gate response, LATENCY cycles later, against OR-reduction.
module or_gate_bist
    import or_bist_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter int unsigned ERR_W      = DEF_ERR_W,
    parameter bit          CONTINUOUS = DEF_CONTINUOUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             first_fail_valid
);

    localparam logic [3:0] DRAIN_LAST = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t           state;
    state_t           state_next;
    logic             launch;
    logic [3:0]       drain_cnt;
    logic             stim_last;
    logic [WIDTH:0]   d_data;
    logic             d_valid;
    logic             mismatch;

    assign stim_last = (stim == '1);

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    launch     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stim_last) begin
                    state_next = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start || CONTINUOUS) begin
                    state_next = ST_RUN;
                    launch     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Expected bit travels with its stimulus so both line up with resp.
    bist_delay #(
        .W     (WIDTH + 1),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .data      ({|stim, stim}),
        .valid     (state == ST_RUN),
        .data_dly  (d_data),
        .valid_dly (d_valid)
    );

    assign mismatch = d_valid && (resp != d_data[WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            stim             <= '0;
            drain_cnt        <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            // Incrementing past all-ones wraps to 0, which is the idle value.
            if (!launch && state == ST_RUN) begin
                stim <= stim + WIDTH'(1);
            end else begin
                stim <= '0;
            end

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;

            if (launch) begin
                err_count        <= '0;
                first_fail       <= '0;
                first_fail_valid <= 1'b0;
            end else if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail       <= d_data[WIDTH-1:0];
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = (state == ST_DONE) && (err_count == '0);

endmodule

// File: tb/tb_or_gate_bist.sv
// Directed bench for or_gate_bist: four parameterisations sharing one clock and reset.
module tb_or_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // A: WIDTH=3, LATENCY=0, selectable gate behaviour
    logic        start_a = 1'b0, resp_a, busy_a, done_a, pass_a, ffv_a;
    logic [2:0]  stim_a, ff_a;
    logic [15:0] err_a;
    int          mode_a = 0;
    assign resp_a = (mode_a == 0) ? |stim_a : (mode_a == 1) ? 1'b0 : 1'b1;

    // B: WIDTH=4, LATENCY=2, gate modelled with one or two register stages
    logic        start_b = 1'b0, resp_b, busy_b, done_b, pass_b, ffv_b;
    logic [3:0]  stim_b, ff_b;
    logic [15:0] err_b;
    logic        r1_b = 1'b0, r2_b = 1'b0, two_stage = 1'b1;
    always @(posedge clk) begin
        r1_b <= |stim_b;
        r2_b <= r1_b;
    end
    assign resp_b = two_stage ? r2_b : r1_b;

    // C: WIDTH=4, LATENCY=0, ERR_W=2, gate stuck at 0
    logic        start_c = 1'b0, busy_c, done_c, pass_c, ffv_c;
    logic [3:0]  stim_c, ff_c;
    logic [1:0]  err_c;

    // D: WIDTH=3, LATENCY=0, CONTINUOUS=1, good gate
    logic        start_d = 1'b0, resp_d, busy_d, done_d, pass_d, ffv_d;
    logic [2:0]  stim_d, ff_d;
    logic [15:0] err_d;
    assign resp_d = |stim_d;

    or_gate_bist #(.WIDTH(3), .LATENCY(0), .ERR_W(16), .CONTINUOUS(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail(ff_a), .first_fail_valid(ffv_a));

    or_gate_bist #(.WIDTH(4), .LATENCY(2), .ERR_W(16), .CONTINUOUS(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail(ff_b), .first_fail_valid(ffv_b));

    or_gate_bist #(.WIDTH(4), .LATENCY(0), .ERR_W(2), .CONTINUOUS(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .resp(1'b0),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .first_fail(ff_c), .first_fail_valid(ffv_c));

    or_gate_bist #(.WIDTH(3), .LATENCY(0), .ERR_W(16), .CONTINUOUS(1'b1)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .stim(stim_d), .resp(resp_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
        .first_fail(ff_d), .first_fail_valid(ffv_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle start pulse; returns #1 after the edge that samples it.
    task automatic pulse(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    endtask

    // Edges until done is seen; 0 if it never rises within the budget.
    task automatic wait_done(input int which, output int cycles);
        logic d;
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            case (which)
                0: d = done_a;
                1: d = done_b;
                2: d = done_c;
                default: d = done_d;
            endcase
            if (d) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic wait_stim_a(input logic [2:0] value);
        for (int i = 0; i < 20; i++) begin
            if (stim_a == value) return;
            @(posedge clk); #1;
        end
    endtask

    int cyc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_ffv", ffv_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_stim", stim_a, 0);

        // A: good gate
        mode_a = 0;
        pulse(0);
        check("a_run_busy", busy_a, 1);
        wait_done(0, cyc);
        check("a_good_cycles", cyc, 8);
        check("a_good_pass", pass_a, 1);
        check("a_good_err", err_a, 0);
        check("a_good_ffv", ffv_a, 0);
        check("a_done_stim", stim_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check("a_hold_done", done_a, 1);
        check("a_hold_pass", pass_a, 1);

        // A: stuck at 0, restarted from DONE
        mode_a = 1;
        pulse(0);
        wait_done(0, cyc);
        check("a_s0_cycles", cyc, 8);
        check("a_s0_err", err_a, 7);
        check("a_s0_ff", ff_a, 3'b001);
        check("a_s0_ffv", ffv_a, 1);
        check("a_s0_pass", pass_a, 0);

        // A: stuck at 1
        mode_a = 2;
        pulse(0);
        wait_done(0, cyc);
        check("a_s1_err", err_a, 1);
        check("a_s1_ff", ff_a, 3'b000);
        check("a_s1_ffv", ffv_a, 1);
        check("a_s1_pass", pass_a, 0);

        // B: latency-matched gate model
        two_stage = 1'b1;
        pulse(1);
        wait_done(1, cyc);
        check("b_2st_cycles", cyc, 18);
        check("b_2st_pass", pass_b, 1);
        check("b_2st_err", err_b, 0);

        // B: gate one cycle early -> s=0 and s=15 mismatch
        two_stage = 1'b0;
        pulse(1);
        wait_done(1, cyc);
        check("b_1st_cycles", cyc, 18);
        check("b_1st_pass", pass_b, 0);
        check("b_1st_err", err_b, 2);
        check("b_1st_ff", ff_b, 0);

        // C: saturation, then an identical second sweep
        pulse(2);
        wait_done(2, cyc);
        check("c_cycles", cyc, 16);
        check("c_err_sat", err_c, 3);
        check("c_ff", ff_c, 1);
        check("c_pass", pass_c, 0);
        pulse(2);
        check("c_clr_err", err_c, 0);
        check("c_clr_ffv", ffv_c, 0);
        check("c_clr_ff", ff_c, 0);
        wait_done(2, cyc);
        check("c2_cycles", cyc, 16);
        check("c2_err_sat", err_c, 3);
        check("c2_ff", ff_c, 1);

        // D: continuous mode re-enters RUN after one DONE cycle
        pulse(3);
        wait_done(3, cyc);
        check("d_cycles", cyc, 8);
        check("d_pass", pass_d, 1);
        @(posedge clk); #1;
        check("d_reentry_done", done_d, 0);
        check("d_reentry_busy", busy_d, 1);
        check("d_reentry_stim", stim_d, 0);
        wait_done(3, cyc);
        check("d2_cycles", cyc, 8);
        check("d2_pass", pass_d, 1);

        // A: start ignored in RUN, then reset mid-sweep
        mode_a = 1;
        pulse(0);
        wait_stim_a(3'd2);
        check("a_mid_err2", err_a, 1);
        pulse(0);
        check("a_ign_stim", stim_a, 3);
        check("a_ign_err", err_a, 2);
        check("a_ign_busy", busy_a, 1);
        wait_stim_a(3'd5);
        check("a_pre_rst_err", err_a, 4);
        check("a_pre_rst_ff", ff_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("a_mrst_stim", stim_a, 0);
        check("a_mrst_busy", busy_a, 0);
        check("a_mrst_done", done_a, 0);
        check("a_mrst_pass", pass_a, 0);
        check("a_mrst_err", err_a, 0);
        check("a_mrst_ff", ff_a, 0);
        check("a_mrst_ffv", ffv_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check("a_idle_stim", stim_a, 0);
        check("a_idle_busy", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/or_gate_bist.md
OR_GATE_BIST -- requirements
Module: or_gate_bist

Interface
REQ-001 Parameter WIDTH, default 10: input count of the OR gate under test (1..20).
REQ-002 Parameter LATENCY, default 0: clock cycles from stim change to the matching resp (0..15).
REQ-003 Parameter ERR_W, default 16: error counter width.
REQ-004 Parameter CONTINUOUS, default 0: 1 = restart the sweep automatically after each pass instead of stopping.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin a sweep; sampled only in IDLE or DONE.
REQ-008 stim  out  WIDTH  registered stimulus driven to the gate under test.
REQ-009 resp  in  1  gate output, sampled every clock.
REQ-010 busy  out  1  high in RUN and DRAIN.
REQ-011 done  out  1  high in DONE.
REQ-012 pass  out  1  high in DONE when err_count == 0.
REQ-013 err_count  out  ERR_W  mismatch count for the current sweep; saturating.
REQ-014 first_fail  out  WIDTH  stimulus value of the first mismatch of the sweep.
REQ-015 first_fail_valid  out  1  first_fail holds a captured value.

Function
REQ-016 FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN after stim == all-ones; direct to DONE if LATENCY == 0.
- DRAIN -> DONE after exactly LATENCY cycles.
- DONE -> RUN on start.
REQ-017 The edge that samples start shall set stim = 0, clear err_count, first_fail and first_fail_valid, and enter RUN.
REQ-018 In RUN, stim shall increment by 1 per cycle, covering 0 .. 2^WIDTH-1 exactly once (2^WIDTH cycles).
REQ-019 Expected value for stim value s is the OR of all bits of s (0 iff s == 0).
- Expected value and s shall be delayed LATENCY cycles with a valid tag.
- resp shall be compared only when the delayed tag is valid.
REQ-020 On a mismatch, err_count shall increment and saturate at 2^ERR_W-1.
- On the first mismatch, the delayed s shall be captured in first_fail and first_fail_valid set.
- Later mismatches shall leave first_fail unchanged.
REQ-021 done shall rise 2^WIDTH+LATENCY cycles after the start-sampling edge.
- All result outputs are final when done rises and shall be held while in DONE.
REQ-022 start while busy shall be ignored.
REQ-023 With CONTINUOUS = 1, DONE shall last exactly one cycle before RUN re-entry without start.
- Results shall clear on re-entry as in REQ-017.
REQ-024 In IDLE and DONE, stim shall hold 0.

Reset
REQ-025 rst shall override all other inputs, including mid-sweep, and apply at the next edge.
REQ-026 Reset values:
- state = IDLE.
- stim = 0, busy = 0, done = 0, pass = 0.
- err_count = 0, first_fail = 0, first_fail_valid = 0.
- all delay-line valid tags cleared.

Structure
REQ-027 Shared package or_bist_pkg shall hold the state enum and the default parameter constants.
REQ-028 Sub-module bist_delay shall implement a parametrised LATENCY-stage shift register (data + valid); LATENCY = 0 shall be a pass-through.

Verification
REQ-029 WIDTH=3, LATENCY=0, resp = OR(stim):
- done rises 8 cycles after start.
- pass = 1, err_count = 0, first_fail_valid = 0.
REQ-030 WIDTH=3, LATENCY=0, resp stuck at 0:
- err_count = 7, first_fail = 3'b001, pass = 0.
REQ-031 WIDTH=3, LATENCY=0, resp stuck at 1:
- err_count = 1, first_fail = 3'b000.
REQ-032 WIDTH=4, LATENCY=2, resp = 2-stage-registered OR(stim):
- pass = 1, done rises 18 cycles after start.
- Same run with a 1-stage model gives pass = 0.
REQ-033 WIDTH=4, ERR_W=2, resp stuck at 0:
- err_count saturates at 3.
- Then start again: results clear and the second sweep repeats identically.
REQ-034 Assert rst at stim = 5 mid-sweep:
- Next cycle all outputs show reset values and state is IDLE.
- start pulsed in RUN has no effect.
